// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: single-outstanding fetch requester feeding a
// small {pc,instr} FIFO, with redirect flush and misaligned-target exception.
module ifetch_queue #(
   parameter int unsigned DEPTH        = 4,
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_0004
) (
   input  logic                     clk,
   input  logic                     resetb,
   output logic                     im_req,
   output logic [31:0]              im_addr,
   input  logic                     im_valid,
   input  logic [31:0]              im_do,
   output logic                     fd_valid,
   output logic [31:0]              fd_instr,
   output logic [31:0]              fd_pc,
   input  logic                     fd_ready,
   input  logic                     redir_valid,
   input  logic [31:0]              redir_pc,
   output logic                     exc_valid,
   output logic [31:0]              exc_mepc,
   output logic [31:0]              exc_mcause,
   output logic [$clog2(DEPTH):0]   fq_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [31:0]   fetch_pc;
   logic [31:0]   req_pc;
   logic [31:0]   pc_mem    [DEPTH];
   logic [31:0]   instr_mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          outstanding;
   logic          discard;

   logic          resp;
   logic          pending;
   logic          push;
   logic          pop;
   logic          issue;
   logic [AW:0]   occ;

   // A response only counts if it answers a request made since reset.
   always_comb begin
      resp    = im_valid & outstanding;
      pending = resp & ~discard;
      occ     = fq_count + {{AW{1'b0}}, pending};
      issue   = resetb & (~outstanding | resp) & (occ < DEPTH_C) & ~redir_valid;
      push    = pending & ~redir_valid;
      pop     = fd_valid & fd_ready & ~redir_valid;
   end

   assign im_req   = issue;
   assign im_addr  = fetch_pc;
   assign fd_valid = (fq_count != '0);
   assign fd_pc    = pc_mem[rd_ptr];
   assign fd_instr = instr_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]    <= req_pc;
         instr_mem[wr_ptr] <= im_do;
      end
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         fetch_pc    <= RESET_VECTOR;
         req_pc      <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         fq_count    <= '0;
         outstanding <= 1'b0;
         discard     <= 1'b0;
         exc_valid   <= 1'b0;
         exc_mepc    <= '0;
         exc_mcause  <= '0;
      end else if (redir_valid) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         fq_count    <= '0;
         // An in-flight request not answered now must be dropped later.
         outstanding <= outstanding & ~resp;
         discard     <= outstanding & ~resp;
         if (redir_pc[1:0] == 2'b00) begin
            fetch_pc  <= redir_pc;
            exc_valid <= 1'b0;
         end else begin
            fetch_pc   <= EXC_VECTOR;
            exc_valid  <= 1'b1;
            exc_mepc   <= redir_pc;
            exc_mcause <= '0;
         end
      end else begin
         exc_valid <= 1'b0;
         if (issue) begin
            req_pc      <= fetch_pc;
            fetch_pc    <= fetch_pc + 32'd4;
            outstanding <= 1'b1;
         end else if (resp) begin
            outstanding <= 1'b0;
         end
         if (resp && discard) begin
            discard <= 1'b0;
         end
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         fq_count <= fq_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
   end

endmodule
